// File: rtl/pet_pkg.sv
// Shared care-command constants and scheduler types.
// The stats block imports the same command encodings.
package pet_pkg;

  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_EAT   = 8'h65;
  localparam logic [7:0] CMD_PLAY  = 8'h70;
  localparam logic [7:0] CMD_BATH  = 8'h62;
  localparam logic [7:0] CMD_SLEEP = 8'h73;
  localparam logic [7:0] CMD_WAKE  = 8'h77;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } sched_state_t;

  typedef enum logic {
    SRC_UART,
    SRC_BTN
  } src_t;

  function automatic logic is_valid_cmd(
    input logic [7:0] c
  );
    return c inside {CMD_EAT, CMD_PLAY,
                     CMD_BATH, CMD_SLEEP,
                     CMD_WAKE};
  endfunction

  // Expects a one-hot (or zero) button vector.
  function automatic logic [7:0] btn_cmd(
    input logic [4:0] oh
  );
    logic [7:0] c;
    c = CMD_IDLE;
    unique case (1'b1)
      oh[0]:   c = CMD_EAT;
      oh[1]:   c = CMD_PLAY;
      oh[2]:   c = CMD_BATH;
      oh[3]:   c = CMD_SLEEP;
      oh[4]:   c = CMD_WAKE;
      default: c = CMD_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/care_cmd_scheduler_fifo.sv
// Small synchronous command FIFO with show-ahead head.
// Full and empty derive from an occupancy counter.
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + (AW+1)'(do_wr)
             - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/care_cmd_scheduler.sv
// Merges UART and button care commands, queues them,
// and replays each as a fixed pulse plus a 0x00 gap.
module care_cmd_scheduler
  import pet_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic       uart_ready,
  input  logic [4:0] btn,
  input  logic       is_sleeping,
  output logic [7:0] cmd_out,
  output logic       busy,
  output logic       fifo_full,
  output logic [7:0] dropped_cnt
);

  localparam int MAXC =
    (HOLD_CYCLES > GAP_CYCLES) ?
    HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES - 1);

  sched_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    cmd_n;
  src_t          rr_last;
  logic [4:0]    btn_prev;
  logic [4:0]    rise;
  logic [4:0]    low;
  logic [2:0]    rise_cnt;
  logic          btn_cand;
  logic          uart_cand;
  logic          btn_win;
  logic          uart_take;
  logic          contested;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic [7:0]    head;
  logic          empty;
  logic          sleep_drop;
  logic [3:0]    drop_inc;
  logic [8:0]    drop_sum;

  assign rise     = btn & ~btn_prev;
  assign low      = rise & (~rise + 5'd1);
  assign btn_cand = |rise;
  assign rise_cnt = 3'(rise[0]) + 3'(rise[1])
                  + 3'(rise[2]) + 3'(rise[3])
                  + 3'(rise[4]);

  assign uart_cand = uart_valid
                  && is_valid_cmd(uart_data);
  assign contested = btn_cand && uart_cand
                  && !fifo_full;
  // Button takes a contested slot only if UART won last.
  assign btn_win = btn_cand && !fifo_full
                && (!uart_cand || rr_last == SRC_UART);

  assign uart_ready = !reset && !fifo_full && !btn_win;
  assign uart_take  = uart_valid && uart_ready;
  assign wr_en      = btn_win || (uart_take && uart_cand);
  assign wr_data    = btn_win ? btn_cmd(low) : uart_data;

  assign busy = (state != IDLE) || !empty;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (empty)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cmd_n      = cmd_out;
    rd_en      = 1'b0;
    sleep_drop = 1'b0;
    unique case (state)
      DRIVE: begin
        if (cnt == HOLD_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
          cmd_n   = CMD_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: ;
    endcase
    // Pop from IDLE or on the final gap cycle.
    if ((state == IDLE ||
         (state == GAP && cnt == GAP_LAST))
        && !empty) begin
      rd_en = 1'b1;
      if (is_sleeping && head != CMD_WAKE) begin
        sleep_drop = 1'b1;
      end else begin
        state_n = DRIVE;
        cnt_n   = '0;
        cmd_n   = head;
      end
    end
  end

  assign drop_inc = 4'(rise_cnt) - 4'(btn_cand)
                  + 4'(btn_cand && !btn_win)
                  + 4'(uart_take && !uart_cand)
                  + 4'(sleep_drop);
  assign drop_sum = 9'(dropped_cnt) + 9'(drop_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_out     <= CMD_IDLE;
      btn_prev    <= '0;
      rr_last     <= SRC_UART;
      dropped_cnt <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cmd_out  <= cmd_n;
      btn_prev <= btn;
      if (contested)
        rr_last <= btn_win ? SRC_BTN : SRC_UART;
      dropped_cnt <= drop_sum[8] ?
                     8'hFF : drop_sum[7:0];
    end
  end

endmodule
